// File: rtl/punc_debug_scanner.sv
// Debug snapshot scanner for PUnC: walks PC, the register file and a memory
// window through the debug read ports and streams each word over valid/ready.
module punc_debug_scanner #(
  parameter int SETTLE_CYCLES = 1,
  parameter int RF_WORDS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_len,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] TAG_PC  = 2'b00;
  localparam logic [1:0] TAG_RF  = 2'b01;
  localparam logic [1:0] TAG_MEM = 2'b10;

  localparam logic [16:0] RF_K        = 17'(RF_WORDS);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [16:0] k_q, k_d, k_nxt, last_k;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] base_q, base_d, len_q, len_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [2:0]  rf_addr_q, rf_addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  tag_q, tag_d;
  logic        last_q, last_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    settle_d   = settle_q;
    base_d     = base_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    rf_addr_d  = rf_addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    last_d     = last_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    k_nxt      = k_q + 17'd1;
    last_k     = RF_K + {1'b0, len_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = mem_base;
          len_d    = mem_len;
          k_d      = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (settle_q == SETTLE_LAST) begin
          valid_d = 1'b1;
          last_d  = (k_q == last_k);
          state_d = EMIT;
          if (k_q == 17'd0) begin
            tag_d  = TAG_PC;
            data_d = pc_debug_data;
          end else if (k_q <= RF_K) begin
            tag_d  = TAG_RF;
            data_d = rf_debug_data;
          end else begin
            tag_d  = TAG_MEM;
            data_d = mem_debug_data;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            k_d      = k_nxt;
            settle_d = '0;
            state_d  = ADDR;
            // Only the port feeding the next item moves; the other one holds.
            if (k_nxt <= RF_K) rf_addr_d = 3'(k_nxt - 17'd1);
            else mem_addr_d = base_q + 16'(k_nxt - RF_K - 17'd1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      settle_q   <= '0;
      base_q     <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      rf_addr_q  <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      settle_q   <= settle_d;
      base_q     <= base_d;
      len_q      <= len_d;
      mem_addr_q <= mem_addr_d;
      rf_addr_q  <= rf_addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_debug_addr = mem_addr_q;
  assign rf_debug_addr  = rf_addr_q;
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_tag        = tag_q;
  assign out_last       = last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_punc_debug_scanner.sv
// Scoreboard bench for punc_debug_scanner: one instance with combinational
// PUnC reads, one with SETTLE_CYCLES=2 against a registered memory.
module tb_punc_debug_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  initial forever @(posedge clk) cyc++;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] data;
    logic        last;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp2_q[$];

  int checks = 0, fails = 0;
  int acc_cnt = 0, done_cnt = 0, last_acc_cyc = -10;
  int acc2 = 0, done2_cnt = 0, prev2 = -1;

  logic [15:0] pc_m;
  logic [15:0] rf_m [8];

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // instance 1: SETTLE_CYCLES=1, combinational reads
  logic        start, out_ready, out_valid, out_last, busy, done;
  logic [15:0] mem_base, mem_len, mem_addr, mem_data, rf_data, pc_data, out_data;
  logic [2:0]  rf_addr;
  logic [1:0]  out_tag;

  assign mem_data = mem_val(mem_addr);
  assign rf_data  = rf_m[rf_addr];
  assign pc_data  = pc_m;

  punc_debug_scanner #(.SETTLE_CYCLES(1), .RF_WORDS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_base(mem_base), .mem_len(mem_len),
    .mem_debug_addr(mem_addr), .rf_debug_addr(rf_addr),
    .mem_debug_data(mem_data), .rf_debug_data(rf_data), .pc_debug_data(pc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_last(out_last), .busy(busy), .done(done)
  );

  // instance 2: SETTLE_CYCLES=2, memory read registered one cycle
  logic        start2, out_valid2, out_last2, busy2, done2;
  logic        ready2 = 1'b1;
  logic [15:0] mem_base2, mem_len2, mem_addr2, mem2_q, rf_data2, out_data2;
  logic [2:0]  rf_addr2;
  logic [1:0]  out_tag2;

  always @(posedge clk) mem2_q <= mem_val(mem_addr2);
  assign rf_data2 = rf_m[rf_addr2];

  punc_debug_scanner #(.SETTLE_CYCLES(2), .RF_WORDS(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mem_base(mem_base2), .mem_len(mem_len2),
    .mem_debug_addr(mem_addr2), .rf_debug_addr(rf_addr2),
    .mem_debug_data(mem2_q), .rf_debug_data(rf_data2), .pc_debug_data(pc_data),
    .out_valid(out_valid2), .out_ready(ready2), .out_data(out_data2),
    .out_tag(out_tag2), .out_last(out_last2), .busy(busy2), .done(done2)
  );

  // monitors: pop and compare on every accepted word
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (out_valid && out_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_word got=%h tag=%b", out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("word_tag", 32'(out_tag), 32'(e.tag));
          chk("word_data", 32'(out_data), 32'(e.data));
          chk("word_last", 32'(out_last), 32'(e.last));
          if (e.tag == 2'b01) chk("rf_addr", 32'(rf_addr), 32'(e.addr));
          if (e.tag == 2'b10) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", 32'(cyc), 32'(last_acc_cyc + 1));
        chk("done_busy_low", 32'(busy), 32'd0);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (out_valid2) begin
        acc2++;
        if (prev2 >= 0) chk("s2_spacing", 32'(cyc - prev2), 32'd3);
        prev2 = cyc;
        if (exp2_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL s2_unexpected_word got=%h", out_data2);
        end else begin
          e = exp2_q.pop_front();
          chk("s2_tag", 32'(out_tag2), 32'(e.tag));
          chk("s2_data", 32'(out_data2), 32'(e.data));
          chk("s2_last", 32'(out_last2), 32'(e.last));
        end
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_scan(input bit which, input logic [15:0] base, input logic [15:0] len);
    exp_t e;
    e = '{tag: 2'b00, data: pc_m, last: 1'b0, addr: 16'h0};
    if (which) exp2_q.push_back(e); else exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e = '{tag: 2'b01, data: rf_m[i], last: (len == 0 && i == 7), addr: 16'(i)};
      if (which) exp2_q.push_back(e); else exp_q.push_back(e);
    end
    for (int j = 0; j < int'(len); j++) begin
      e = '{tag: 2'b10, data: mem_val(16'(base + 16'(j))), last: (j == int'(len) - 1),
            addr: 16'(base + 16'(j))};
      if (which) exp2_q.push_back(e); else exp_q.push_back(e);
    end
  endtask

  task automatic scan_start(input logic [15:0] base, input logic [15:0] len);
    mem_base = base; mem_len = len; start = 1'b1;
    tick();
    start = 1'b0; mem_base = 16'hDEAD; mem_len = 16'h0007;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    if (!out_valid) begin
      checks++; fails++;
      $display("FAIL wait_valid_timeout");
    end
  endtask

  task automatic wait_word(input logic [15:0] d);
    int n = 0;
    while (!(out_valid && out_data == d) && n < 200) begin tick(); n++; end
    if (!(out_valid && out_data == d)) begin
      checks++; fails++;
      $display("FAIL wait_word_timeout got=%h expected=%h", out_data, d);
    end
  endtask

  task automatic finish_scan(input string nm, input int a0, input int d0, input int words);
    int n = 0;
    while (busy && n < 500) begin tick(); n++; end
    tick();
    chk({nm, "_busy_drop"}, 32'(busy), 32'd0);
    chk({nm, "_word_count"}, 32'(acc_cnt - a0), 32'(words));
    chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, a0, d0;
    start = 0; mem_base = 0; mem_len = 0; out_ready = 1;
    start2 = 0; mem_base2 = 0; mem_len2 = 0;
    pc_m = 16'h3000;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h1110 + 16'(i);

    // async reset asserted mid-cycle
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_tag_last", 32'({out_tag, out_last}), 32'd0);
    chk("rst_addrs", 32'({mem_addr, rf_addr}), 32'd0);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // basic scan, no memory window
    a0 = acc_cnt; d0 = done_cnt;
    push_scan(0, 16'h0, 16'h0);
    scan_start(16'h0, 16'h0);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_valid(n);
    chk("basic_first_latency", 32'(n), 32'd1);
    finish_scan("basic", a0, d0, 9);

    // memory window wrapping past FFFF
    pc_m = 16'h3A5C;
    a0 = acc_cnt; d0 = done_cnt;
    push_scan(0, 16'hFFFE, 16'd3);
    scan_start(16'hFFFE, 16'd3);
    finish_scan("wrap", a0, d0, 12);

    // backpressure on RF3
    a0 = acc_cnt; d0 = done_cnt;
    push_scan(0, 16'h0, 16'h0);
    scan_start(16'h0, 16'h0);
    wait_word(16'h1113);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_data_held", 32'(out_data), 32'h1113);
      chk("bp_addr_held", 32'(rf_addr), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    wait_valid(n);
    chk("bp_resume_latency", 32'(n), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'h1114);
    finish_scan("bp", a0, d0, 9);

    // start ignored mid-scan, then reset during ADDR of word 6
    a0 = acc_cnt; d0 = done_cnt;
    push_scan(0, 16'h0, 16'h0);
    scan_start(16'h0, 16'h0);
    wait_word(16'h1113);
    start = 1'b1; mem_len = 16'd5;
    tick();
    start = 1'b0;
    wait_word(16'h1114);
    tick();
    chk("mid_in_addr_busy", 32'(busy), 32'd1);
    chk("mid_in_addr_valid", 32'(out_valid), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_outs", 32'({out_data, out_tag, out_last, done}), 32'd0);
    chk("mid_words_before_rst", 32'(acc_cnt - a0), 32'd6);
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_idle_after_rst", 32'(busy), 32'd0);
    pc_m = 16'h0042;
    a0 = acc_cnt; d0 = done_cnt;
    push_scan(0, 16'h0, 16'h0);
    scan_start(16'h0, 16'h0);
    finish_scan("rescan", a0, d0, 9);

    // SETTLE_CYCLES=2 against registered memory
    prev2 = -1;
    push_scan(1, 16'h0100, 16'd4);
    mem_base2 = 16'h0100; mem_len2 = 16'd4; start2 = 1'b1;
    tick();
    start2 = 1'b0; mem_base2 = 16'h0; mem_len2 = 16'h0;
    n = 0;
    while (!out_valid2 && n < 100) begin tick(); n++; end
    chk("s2_first_latency", 32'(n), 32'd2);
    n = 0;
    while (busy2 && n < 500) begin tick(); n++; end
    tick();
    chk("s2_word_count", 32'(acc2), 32'd13);
    chk("s2_done_pulses", 32'(done2_cnt), 32'd1);
    chk("s2_queue_empty", 32'(exp2_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/punc_debug_scanner.md
Name: punc_debug_scanner

Overview:
- Drives the PUnC debug read ports (mem_debug_addr, rf_debug_addr) and collects the returned data (mem_debug_data, rf_debug_data, pc_debug_data).
- On a start pulse it emits a snapshot as a word stream over a valid/ready interface: PC, then RF0..RF7, then a memory window.
- Sits beside the PUnC top level in the bench/FPGA wrapper and feeds a UART or logger.

Parameters:
- SETTLE_CYCLES, 1, cycles a debug address is held before its data is sampled (legal 1..15). 1 covers combinational reads; 2 covers one-cycle synchronous reads.
- RF_WORDS, 8, register file entries scanned (addresses 0..RF_WORDS-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- mem_base  in  16  first memory address of the window; latched at start.
- mem_len  in  16  memory words to scan (0 = none); latched at start.
- mem_debug_addr  out  16  address driven to PUnC mem_debug_addr.
- rf_debug_addr  out  3  address driven to PUnC rf_debug_addr.
- mem_debug_data  in  16  from PUnC.
- rf_debug_data  in  16  from PUnC.
- pc_debug_data  in  16  from PUnC.
- out_valid  out  1  out_data/out_tag/out_last hold a word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_data  out  16  snapshot word.
- out_tag  out  2  source of the word: 00 PC, 01 RF, 10 MEM (11 unused).
- out_last  out  1  final word of the scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0: addresses, out_*, busy, done.
  - Item counter, settle counter and latched base/len cleared.
  - Reset mid-scan abandons the scan; no done pulse.
- Items are indexed k = 0 .. 8+mem_len (17-bit counter):
  - k=0: PC.
  - k=1..RF_WORDS: RF[k-1], with rf_debug_addr = k-1.
  - k>RF_WORDS: MEM, with mem_debug_addr = (base + k-1-RF_WORDS) mod 2^16. The window wraps past 16'hFFFF to 16'h0000.
  - Last item: k = RF_WORDS + len.
- States: IDLE, ADDR, EMIT, DONE.
- IDLE: busy=0. When start=1, latch mem_base/mem_len, set k=0 and settle=0, and go to ADDR. busy=1 from the next cycle.
- ADDR:
  - Address outputs reflect item k throughout.
  - rf_debug_addr holds its previous value during PC/MEM items; mem_debug_addr holds during PC/RF items.
  - Count SETTLE_CYCLES cycles. On the edge ending the final count, register the selected data into out_data, set out_tag, set out_last=(k==last), set out_valid=1, and go to EMIT.
- EMIT:
  - out_valid=1, with out_data/out_tag/out_last stable until the handshake.
  - On out_valid & out_ready: clear out_valid.
    - If out_last: go to DONE.
    - Otherwise: k+=1, settle=0, go to ADDR.
  - out_ready is ignored outside EMIT.
- DONE: done=1 for exactly one cycle. busy drops to 0 in the same cycle. out_last clears. Go to IDLE.
- Latency: with start at cycle t and SETTLE_CYCLES=S:
  - First out_valid rises at cycle t+1+S.
  - Each subsequent word follows its predecessor's handshake by S+1 cycles (min 1 word per S+1 cycles).
- start while busy (ADDR/EMIT/DONE) is ignored; mem_base/mem_len changes mid-scan have no effect.
- PUnC keeps running during a scan; each word reflects its own sample instant (no coherence guarantee).
- Total words per scan = 1 + RF_WORDS + mem_len.

Test Plan:
- Reset and idle: rst=0 mid-cycle → all outputs 0 immediately (async). Release with start=0 for 20 cycles → busy=0, out_valid=0.
- Basic scan, mem_len=0, S=1, out_ready=1, PC=16'h3000, RF[i]=16'h1110+i → 9 words: (00,3000), then (01,1110..1117). out_last only on 1117. First valid 2 cycles after start. done pulse 1 cycle after last accept.
- Memory window with wrap: mem_base=16'hFFFE, mem_len=3 → mem_debug_addr sequence FFFE, FFFF, 0000. Words tagged 10 carry the memory contents. out_last on the third MEM word. 12 words total.
- Backpressure: hold out_ready=0 for 5 cycles on the RF3 word → out_valid stays 1 and out_data stays RF3 value. No address advance until ready=1; then RF4 appears S+1 cycles later.
- Ignored start and mid-scan reset: pulse start during EMIT of word 4 → no restart, word count unchanged. Assert rst=0 during ADDR of word 6 → outputs clear, no done. A new start after release yields a full scan from PC.
- SETTLE_CYCLES=2 with a one-cycle registered memory model → every MEM word matches the addressed contents. Inter-word spacing is 3 cycles with ready=1.
